// File: rtl/mem_wb_stage_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mem_wb_stage_pkg
// Purpose  : Shared selector/size encodings and state type for mem_wb_stage.
// Revision : 1.0 - initial release
// ============================================================================
package mem_wb_stage_pkg;

    localparam logic [1:0] WB_SEL_PC  = 2'b00;
    localparam logic [1:0] WB_SEL_ALU = 2'b01;
    localparam logic [1:0] WB_SEL_MEM = 2'b10;

    localparam logic [1:0] LD_WORD = 2'b00;
    localparam logic [1:0] LD_HALF = 2'b01;
    localparam logic [1:0] LD_BYTE = 2'b10;

    typedef enum logic [0:0] {
        PASS = 1'b0,
        WAIT = 1'b1
    } wb_state_e;

endpackage
`default_nettype wire

// File: rtl/mem_wb_stage_load_formatter.sv
`default_nettype none
// ============================================================================
// Module   : load_formatter
// Purpose  : Big-endian sub-word extraction with zero/sign extension.
// Revision : 1.0 - initial release
// ============================================================================
module load_formatter #(
    parameter int DATA_W = 32
) (
    input  logic [DATA_W-1:0] raw,
    input  logic [1:0]        load_size,
    input  logic [1:0]        byte_offset,
    input  logic              load_signed,
    output logic [DATA_W-1:0] formatted
);
    import mem_wb_stage_pkg::*;

    logic [15:0] w_half;
    logic [7:0]  w_byte;

    always_comb begin
        w_half    = 16'h0000;
        w_byte    = 8'h00;
        formatted = raw;
        case (load_size)
            LD_HALF: begin
                // Offset 0 addresses the most significant halfword.
                w_half    = byte_offset[1] ? raw[15:0] : raw[31:16];
                formatted = {{(DATA_W-16){load_signed & w_half[15]}}, w_half};
            end
            LD_BYTE: begin
                case (byte_offset)
                    2'd0:    w_byte = raw[31:24];
                    2'd1:    w_byte = raw[23:16];
                    2'd2:    w_byte = raw[15:8];
                    default: w_byte = raw[7:0];
                endcase
                formatted = {{(DATA_W-8){load_signed & w_byte[7]}}, w_byte};
            end
            default: formatted = raw;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/mem_wb_stage.sv
`default_nettype none
// ============================================================================
// Module   : mem_wb_stage
// Purpose  : MEM/WB pipeline register, write-back mux and load-wait stall.
//            Optional macro WB_STALL_CNT_EN adds a saturating stall counter.
// Revision : 1.0 - initial release
// ============================================================================
module mem_wb_stage #(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  mem_valid,
    input  logic                  mem_reg_write,
    input  logic [REG_ADDR_W-1:0] mem_rd,
    input  logic [1:0]            mem_sel,
    input  logic [DATA_W-1:0]     mem_pc,
    input  logic [DATA_W-1:0]     mem_alu_out,
    input  logic [DATA_W-1:0]     mem_load_data,
    input  logic [1:0]            mem_load_size,
    input  logic                  mem_load_signed,
    input  logic [1:0]            mem_byte_offset,
    input  logic                  dmem_ready,
    input  logic                  flush,
    output logic                  stall_req,
    output logic                  wb_valid,
    output logic                  wb_reg_write,
    output logic [REG_ADDR_W-1:0] wb_rd,
    output logic [DATA_W-1:0]     wb_data
`ifdef WB_STALL_CNT_EN
   ,output logic [31:0]           wb_stall_cycles
`endif
);
    import mem_wb_stage_pkg::*;

    wb_state_e             r_state;
    wb_state_e             w_state_nxt;
    logic                  w_is_load;
    logic                  w_capture;
    logic                  w_stall;
    logic [DATA_W-1:0]     w_load_fmt;
    logic [DATA_W-1:0]     w_wb_data_nxt;
    logic                  r_wb_valid;
    logic                  r_wb_reg_write;
    logic [REG_ADDR_W-1:0] r_wb_rd;
    logic [DATA_W-1:0]     r_wb_data;

    load_formatter #(
        .DATA_W (DATA_W)
    ) u_load_formatter (
        .raw         (mem_load_data),
        .load_size   (mem_load_size),
        .byte_offset (mem_byte_offset),
        .load_signed (mem_load_signed),
        .formatted   (w_load_fmt)
    );

    assign w_is_load = mem_valid & (mem_sel == WB_SEL_MEM);

    // Flush wins over everything: bubble in, back to PASS, no stall.
    always_comb begin
        w_state_nxt = r_state;
        w_stall     = 1'b0;
        w_capture   = 1'b0;
        if (flush) begin
            w_state_nxt = PASS;
        end else begin
            case (r_state)
                PASS: begin
                    if (w_is_load && !dmem_ready) begin
                        w_stall     = 1'b1;
                        w_state_nxt = WAIT;
                    end else begin
                        w_capture = 1'b1;
                    end
                end
                WAIT: begin
                    if (dmem_ready) begin
                        w_capture   = 1'b1;
                        w_state_nxt = PASS;
                    end else begin
                        w_stall = 1'b1;
                    end
                end
                default: w_state_nxt = PASS;
            endcase
        end
    end

    always_comb begin
        w_wb_data_nxt = mem_alu_out;
        case (mem_sel)
            WB_SEL_PC:  w_wb_data_nxt = mem_pc;
            WB_SEL_MEM: w_wb_data_nxt = w_load_fmt;
            default:    w_wb_data_nxt = mem_alu_out;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= PASS;
            r_wb_valid     <= 1'b0;
            r_wb_reg_write <= 1'b0;
            r_wb_rd        <= '0;
            r_wb_data      <= '0;
        end else begin
            r_state        <= w_state_nxt;
            r_wb_valid     <= w_capture & mem_valid;
            r_wb_reg_write <= w_capture & mem_valid & mem_reg_write & (mem_rd != '0);
            if (w_capture) begin
                r_wb_rd   <= mem_rd;
                r_wb_data <= w_wb_data_nxt;
            end
        end
    end

    // Gated by reset so every output reads zero while reset is held.
    assign stall_req    = w_stall & rst_n;
    assign wb_valid     = r_wb_valid;
    assign wb_reg_write = r_wb_reg_write;
    assign wb_rd        = r_wb_rd;
    assign wb_data      = r_wb_data;

`ifdef WB_STALL_CNT_EN
    logic [31:0] r_stall_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_cnt <= '0;
        end else if (stall_req && (r_stall_cnt != 32'hFFFF_FFFF)) begin
            r_stall_cnt <= r_stall_cnt + 32'd1;
        end
    end

    assign wb_stall_cycles = r_stall_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mem_wb_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_wb_stage
// Purpose  : Self-checking bench for mem_wb_stage against a behavioural model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_wb_stage;

    localparam int DATA_W     = 32;
    localparam int REG_ADDR_W = 5;

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic                  mem_valid;
    logic                  mem_reg_write;
    logic [REG_ADDR_W-1:0] mem_rd;
    logic [1:0]            mem_sel;
    logic [DATA_W-1:0]     mem_pc;
    logic [DATA_W-1:0]     mem_alu_out;
    logic [DATA_W-1:0]     mem_load_data;
    logic [1:0]            mem_load_size;
    logic                  mem_load_signed;
    logic [1:0]            mem_byte_offset;
    logic                  dmem_ready;
    logic                  flush;
    logic                  stall_req;
    logic                  wb_valid;
    logic                  wb_reg_write;
    logic [REG_ADDR_W-1:0] wb_rd;
    logic [DATA_W-1:0]     wb_data;
`ifdef WB_STALL_CNT_EN
    logic [31:0]           wb_stall_cycles;
`endif

    int          n_checks = 0;
    int          n_errors = 0;
    int unsigned exp_cnt  = 0;
    logic        last_stall;

    mem_wb_stage #(
        .DATA_W     (DATA_W),
        .REG_ADDR_W (REG_ADDR_W)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .mem_valid       (mem_valid),
        .mem_reg_write   (mem_reg_write),
        .mem_rd          (mem_rd),
        .mem_sel         (mem_sel),
        .mem_pc          (mem_pc),
        .mem_alu_out     (mem_alu_out),
        .mem_load_data   (mem_load_data),
        .mem_load_size   (mem_load_size),
        .mem_load_signed (mem_load_signed),
        .mem_byte_offset (mem_byte_offset),
        .dmem_ready      (dmem_ready),
        .flush           (flush),
        .stall_req       (stall_req),
        .wb_valid        (wb_valid),
        .wb_reg_write    (wb_reg_write),
        .wb_rd           (wb_rd),
        .wb_data         (wb_data)
`ifdef WB_STALL_CNT_EN
       ,.wb_stall_cycles (wb_stall_cycles)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Big-endian extraction by shift-and-mask arithmetic.
    function automatic logic [31:0] ref_load(input logic [31:0] raw, input logic [1:0] size,
                                             input logic [1:0] off, input logic sgn);
        logic [31:0] v;
        int          width;
        int          shift;
        if (size == 2'd1) begin
            width = 16;
            shift = off[1] ? 0 : 16;
        end else if (size == 2'd2) begin
            width = 8;
            shift = (3 - int'(off)) * 8;
        end else begin
            return raw;
        end
        v = (raw >> shift) & ((32'd1 << width) - 32'd1);
        if (sgn && v[width-1]) v = v | (32'hFFFF_FFFF << width);
        return v;
    endfunction

    function automatic logic [31:0] ref_data();
        if (mem_sel == 2'b00) return mem_pc;
        if (mem_sel == 2'b10) return ref_load(mem_load_data, mem_load_size, mem_byte_offset, mem_load_signed);
        return mem_alu_out;
    endfunction

    task automatic drive(input logic v, input logic rw, input logic [4:0] rd, input logic [1:0] sel,
                         input logic [31:0] pc, input logic [31:0] alu, input logic [31:0] raw,
                         input logic [1:0] size, input logic sgn, input logic [1:0] off,
                         input logic rdy, input logic fl);
        mem_valid = v;       mem_reg_write = rw;  mem_rd = rd;          mem_sel = sel;
        mem_pc = pc;         mem_alu_out = alu;   mem_load_data = raw;  mem_load_size = size;
        mem_load_signed = sgn; mem_byte_offset = off; dmem_ready = rdy; flush = fl;
    endtask

    // One cycle: the MEM instruction stalls iff it is an unflushed load whose data
    // is not yet ready (upstream holds it stable across the wait); otherwise WB
    // sees it one edge later.
    task automatic step(input string tag);
        logic        e_stall, e_valid, e_rw;
        logic [4:0]  e_rd;
        logic [31:0] e_data;
        @(negedge clk);
        e_stall = !flush && mem_valid && (mem_sel == 2'b10) && !dmem_ready;
        check({tag, ".stall"}, {31'd0, stall_req}, {31'd0, e_stall});
        if (e_stall && exp_cnt != 32'hFFFF_FFFF) exp_cnt++;
        e_valid = mem_valid && !flush && !e_stall;
        e_rw    = e_valid && mem_reg_write && (mem_rd != 5'd0);
        e_rd    = mem_rd;
        e_data  = ref_data();
        last_stall = e_stall;
        @(posedge clk);
        #1;
        check({tag, ".valid"}, {31'd0, wb_valid}, {31'd0, e_valid});
        check({tag, ".rw"}, {31'd0, wb_reg_write}, {31'd0, e_rw});
        if (e_valid) begin
            check({tag, ".rd"}, {27'd0, wb_rd}, {27'd0, e_rd});
            check({tag, ".data"}, wb_data, e_data);
        end
`ifdef WB_STALL_CNT_EN
        check({tag, ".cnt"}, wb_stall_cycles, exp_cnt);
`endif
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, ".stall"}, {31'd0, stall_req}, 32'd0);
        check({tag, ".valid"}, {31'd0, wb_valid}, 32'd0);
        check({tag, ".rw"}, {31'd0, wb_reg_write}, 32'd0);
        check({tag, ".rd"}, {27'd0, wb_rd}, 32'd0);
        check({tag, ".data"}, wb_data, 32'd0);
`ifdef WB_STALL_CNT_EN
        check({tag, ".cnt"}, wb_stall_cycles, 32'd0);
`endif
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish within time limit");
        $fatal(1, "timeout");
    end

    initial begin
        logic [1:0] sel;
        rst_n = 1'b0;
        drive(0, 0, 0, 2'b00, 0, 0, 0, 2'b00, 0, 2'b00, 0, 0);
        #12;
        check_all_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        drive(1, 1, 5, 2'b01, 32'h0, 32'h0000_1234, 32'h0, 2'b00, 0, 2'b00, 1, 0);
        step("alu");
        drive(1, 1, 15, 2'b00, 32'h0000_0400, 32'h0, 32'h0, 2'b00, 0, 2'b00, 1, 0);
        step("pc");
        drive(1, 1, 7, 2'b10, 32'h0, 32'h0, 32'h12F4_5678, 2'b10, 1, 2'd1, 1, 0);
        step("lb_s");
        check("lb_s.const", wb_data, 32'hFFFF_FFF4);
        drive(1, 1, 7, 2'b10, 32'h0, 32'h0, 32'h12F4_5678, 2'b10, 0, 2'd1, 1, 0);
        step("lb_u");
        check("lb_u.const", wb_data, 32'h0000_00F4);
        drive(1, 1, 8, 2'b10, 32'h0, 32'h0, 32'h0000_8001, 2'b01, 1, 2'd2, 1, 0);
        step("lh_s");
        check("lh_s.const", wb_data, 32'hFFFF_8001);

        // Load waiting three cycles for memory.
        drive(1, 1, 9, 2'b10, 32'h0, 32'h0, 32'hCAFE_BABE, 2'b00, 0, 2'd3, 0, 0);
        for (int i = 0; i < 3; i++) step("lw_wait");
        dmem_ready = 1'b1;
        step("lw_done");
        check("lw_done.const", wb_data, 32'hCAFE_BABE);
`ifdef WB_STALL_CNT_EN
        check("lw_done.cnt3", wb_stall_cycles, 32'd3);
`endif

        // Flush while waiting, with data arriving in the same cycle.
        drive(1, 1, 10, 2'b10, 32'h0, 32'h0, 32'h1111_2222, 2'b00, 0, 2'd0, 0, 0);
        step("fl_enter");
        dmem_ready = 1'b1;
        flush      = 1'b1;
        step("fl_wait");
        drive(1, 1, 11, 2'b01, 32'h0, 32'h5555_AAAA, 32'h0, 2'b00, 0, 2'd0, 0, 0);
        step("fl_after");

        // Asynchronous reset while waiting.
        drive(1, 1, 12, 2'b10, 32'h0, 32'h0, 32'h3333_4444, 2'b00, 0, 2'd0, 0, 0);
        step("rst_enter");
        #2;
        rst_n = 1'b0;
        #1;
        check_all_zero("rst_wait");
        exp_cnt = 0;
        drive(0, 0, 0, 2'b00, 0, 0, 0, 2'b00, 0, 2'b00, 0, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        drive(1, 1, 0, 2'b01, 32'h0, 32'hDEAD_0001, 32'h0, 2'b00, 0, 2'd0, 1, 0);
        step("rd0");

        last_stall = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (last_stall) begin
                dmem_ready = ($urandom_range(0, 3) == 0);
                flush      = ($urandom_range(0, 9) == 0);
            end else begin
                sel = 2'($urandom_range(0, 3));
                drive(($urandom_range(0, 7) != 0), 1'($urandom), 5'($urandom), sel,
                      $urandom, $urandom, $urandom, 2'($urandom), 1'($urandom), 2'($urandom),
                      1'($urandom), ($urandom_range(0, 9) == 0));
            end
            step("rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
